// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit -- fetch PC register and next-PC generator
//
// Purpose:
//   Holds the fetch PC and resolves branch/jump conditions for the
//   instruction in ID. Handles stall hold, buffering of a redirect that
//   resolves during a stall, exception vectoring and eret.
//
// Optional feature (compile-time macro PC_ALIGN_CHK_EN):
//   When the macro is defined, a redirect (branch, jump, pending redirect or
//   eret) whose target has target[1:0] != 0 is not followed. The PC goes to
//   EXC_VEC instead, any pending redirect is dropped, and adel pulses high
//   for one cycle. When the macro is undefined, targets are used as they are
//   and adel is tied to 0.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high
//   stall      in   1      hold PC
//   br_op      in   4      ID instruction class (0 seq, 1 beq, 2 bne, 3 blez,
//                          4 bgtz, 5 bltz, 6 bgez, 7 j/jal, 8 jr/jalr, else seq)
//   pc_id      in   WIDTH  PC of the instruction in ID
//   rs_val     in   WIDTH  forwarded rs operand
//   rt_val     in   WIDTH  forwarded rt operand
//   imm26      in   26     instr_index; [15:0] is the branch offset
//   exc_req    in   1      take exception this cycle
//   eret       in   1      return from exception
//   epc        in   WIDTH  eret target
//   pc         out  WIDTH  current fetch PC (registered)
//   pc_plus8   out  WIDTH  pc_id + 8 (link value)
//   taken      out  1      ID branch/jump redirects (combinational)
//   flush_slot out  1      taken, no delay slot, not stalled
//   adel       out  1      misaligned redirect seen (feature build only)
// ============================================================================
module pc_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_4180),
    parameter int unsigned      DELAY_SLOT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [3:0]       br_op,
    input  logic [WIDTH-1:0] pc_id,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [25:0]      imm26,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus8,
    output logic             taken,
    output logic             flush_slot,
    output logic             adel
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_pc;
    logic             r_pend_v;
    logic [WIDTH-1:0] r_pend_pc;

    // ------------------------------------------------------------------
    // Target generation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_pc_id_plus4;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_j_tgt;

    assign w_pc_id_plus4 = pc_id + WIDTH'(4);
    assign pc_plus8      = pc_id + WIDTH'(8);
    assign w_br_off      = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
    assign w_br_tgt      = w_pc_id_plus4 + w_br_off;

    // Jump target keeps the region bits above bit 27 of pc_id+4; at the
    // minimum width there are none.
    generate
        if (WIDTH > 28) begin : g_j_region
            assign w_j_tgt = {w_pc_id_plus4[WIDTH-1:28], imm26, 2'b00};
        end else begin : g_j_noregion
            assign w_j_tgt = {imm26, 2'b00};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Condition resolution (signed compares)
    // ------------------------------------------------------------------
    logic             w_taken;
    logic [WIDTH-1:0] w_tgt;

    always_comb begin
        w_taken = 1'b0;
        w_tgt   = w_br_tgt;
        case (br_op)
            4'd1: w_taken = (rs_val == rt_val);
            4'd2: w_taken = (rs_val != rt_val);
            4'd3: w_taken = ($signed(rs_val) <= 0);
            4'd4: w_taken = ($signed(rs_val) >  0);
            4'd5: w_taken = ($signed(rs_val) <  0);
            4'd6: w_taken = ($signed(rs_val) >= 0);
            4'd7: begin
                w_taken = 1'b1;
                w_tgt   = w_j_tgt;
            end
            4'd8: begin
                w_taken = 1'b1;
                w_tgt   = rs_val;
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign taken      = w_taken;
    assign flush_slot = w_taken & (DELAY_SLOT == 0) & ~stall;
    assign pc         = r_pc;

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pend_v_next;
    logic [WIDTH-1:0] w_pend_pc_next;
    logic             w_redirect;
    logic [WIDTH-1:0] w_redir_tgt;
`ifdef PC_ALIGN_CHK_EN
    logic             w_adel_next;
    logic             r_adel;
`endif

    always_comb begin
        w_pc_next      = r_pc + WIDTH'(4);
        w_pend_v_next  = r_pend_v;
        w_pend_pc_next = r_pend_pc;
        w_redirect     = 1'b0;
        w_redir_tgt    = w_tgt;
`ifdef PC_ALIGN_CHK_EN
        w_adel_next    = 1'b0;
`endif
        if (exc_req) begin
            w_pc_next     = EXC_VEC;
            w_pend_v_next = 1'b0;
        end else if (eret) begin
            w_redirect    = 1'b1;
            w_redir_tgt   = epc;
            w_pend_v_next = 1'b0;
        end else if (stall) begin
            w_pc_next = r_pc;
            // Only the first redirect seen during a stall is kept; later
            // ID contents while stalled are the same or the delay slot.
            if (w_taken && !r_pend_v) begin
                w_pend_v_next  = 1'b1;
                w_pend_pc_next = w_tgt;
            end
        end else if (r_pend_v) begin
            // The instruction in ID now is the buffered branch's delay
            // slot, so its own taken result is ignored.
            w_redirect    = 1'b1;
            w_redir_tgt   = r_pend_pc;
            w_pend_v_next = 1'b0;
        end else if (w_taken) begin
            w_redirect  = 1'b1;
            w_redir_tgt = w_tgt;
        end

        if (w_redirect) begin
`ifdef PC_ALIGN_CHK_EN
            if (w_redir_tgt[1:0] != 2'b00) begin
                w_pc_next     = EXC_VEC;
                w_pend_v_next = 1'b0;
                w_adel_next   = 1'b1;
            end else begin
                w_pc_next = w_redir_tgt;
            end
`else
            w_pc_next = w_redir_tgt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_pc      <= w_pc_next;
            r_pend_v  <= w_pend_v_next;
            r_pend_pc <= w_pend_pc_next;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adel <= 1'b0;
        end else begin
            r_adel <= w_adel_next;
        end
    end
    assign adel = r_adel;
`else
    assign adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ============================================================================
// tb_pc_unit -- self-checking bench for pc_unit (WIDTH=32, default params)
//
// The stimulus process drives one cycle at a time and pushes the expected
// outputs for that cycle into a queue; the monitor pops and compares on the
// falling edge.
// ============================================================================
module tb_pc_unit;

    localparam int unsigned DS = 1;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [3:0]  br_op;
    logic [31:0] pc_id;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [25:0] imm26;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        taken;
    logic        flush_slot;
    logic        adel;

    pc_unit #(
        .WIDTH      (32),
        .RESET_PC   (32'h0000_3000),
        .EXC_VEC    (32'h0000_4180),
        .DELAY_SLOT (DS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_op      (br_op),
        .pc_id      (pc_id),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .imm26      (imm26),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .pc         (pc),
        .pc_plus8   (pc_plus8),
        .taken      (taken),
        .flush_slot (flush_slot),
        .adel       (adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] p8;
        logic        fl;
        logic        ad;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pc",    pc,                 e.pc);
            chk(e.name, "taken", {31'd0, taken},     {31'd0, e.tk});
            chk(e.name, "p8",    pc_plus8,           e.p8);
            chk(e.name, "flush", {31'd0, flush_slot},{31'd0, e.fl});
            chk(e.name, "adel",  {31'd0, adel},      {31'd0, e.ad});
            $display("txn %-10s pc=%h taken=%b pc_plus8=%h adel=%b",
                     e.name, pc, taken, pc_plus8, adel);
        end
    end

    // Drive one cycle: inputs, then expected values for this cycle
    // (exp_pc is the registered PC during this cycle).
    task automatic cyc(input string nm, input logic rst, input logic st,
                       input logic [3:0] op, input logic [31:0] pid,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [25:0] imm, input logic ex, input logic er,
                       input logic [31:0] ep, input logic [31:0] exp_pc,
                       input logic exp_tk, input logic exp_ad);
        exp_t e;
        reset   = rst;
        stall   = st;
        br_op   = op;
        pc_id   = pid;
        rs_val  = rs;
        rt_val  = rt;
        imm26   = imm;
        exc_req = ex;
        eret    = er;
        epc     = ep;
        e.name  = nm;
        e.pc    = exp_pc;
        e.tk    = exp_tk;
        e.p8    = pid + 32'd8;
        e.fl    = exp_tk && (DS == 0) && !st;
        e.ad    = exp_ad;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1; stall = 1'b0; br_op = 4'd0; pc_id = '0;
        rs_val = '0; rt_val = '0; imm26 = '0; exc_req = 1'b0;
        eret = 1'b0; epc = '0;
        @(posedge clk);
        #1;
        //   name        rst st  op    pc_id         rs            rt      imm26         ex  er  epc           exp_pc        tk  ad
        cyc("rst_hold",   1, 0, 4'd0, 32'h0000_3000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3000, 0, 0);
        cyc("seq0",       0, 0, 4'd0, 32'h0000_3000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3000, 0, 0);
        cyc("seq1",       0, 0, 4'd0, 32'h0000_3000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3004, 0, 0);
        cyc("seq2",       0, 0, 4'd9, 32'h0000_3004, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3008, 0, 0);
        cyc("seq3",       0, 0, 4'd0, 32'h0000_3008, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_300C, 0, 0);
        cyc("beq_tk",     0, 0, 4'd1, 32'h0000_3004, 32'h5,       32'h5, 26'h000FFFF, 0, 0, 32'h0,       32'h0000_3010, 1, 0);
        cyc("beq_nt",     0, 0, 4'd1, 32'h0000_3004, 32'h5,       32'h6, 26'h000FFFF, 0, 0, 32'h0,       32'h0000_3004, 0, 0);
        cyc("bgtz_neg",   0, 0, 4'd4, 32'h0000_3004, 32'h8000_0000, 32'h0, 26'h10,    0, 0, 32'h0,       32'h0000_3008, 0, 0);
        cyc("bgtz_tk",    0, 0, 4'd4, 32'h0000_3008, 32'h1,       32'h0, 26'h4,       0, 0, 32'h0,       32'h0000_300C, 1, 0);
        cyc("j",          0, 0, 4'd7, 32'h0000_3010, 32'h0,       32'h0, 26'h0000C10, 0, 0, 32'h0,       32'h0000_301C, 1, 0);
        cyc("st_jr",      0, 1, 4'd8, 32'h0000_3040, 32'h3100,    32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3040, 1, 0);
        cyc("st_beq",     0, 1, 4'd1, 32'h0000_3000, 32'h0,       32'h0, 26'h10,      0, 0, 32'h0,       32'h0000_3040, 1, 0);
        cyc("st_seq",     0, 1, 4'd0, 32'h0000_3000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3040, 0, 0);
        cyc("pend_use",   0, 0, 4'd7, 32'h0000_3044, 32'h0,       32'h0, 26'h100,     0, 0, 32'h0,       32'h0000_3040, 1, 0);
        cyc("after_pend", 0, 0, 4'd0, 32'h0000_3100, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_3100, 0, 0);
        cyc("st_bne",     0, 1, 4'd2, 32'h0000_3100, 32'h1,       32'h2, 26'h8,       0, 0, 32'h0,       32'h0000_3104, 1, 0);
        cyc("st_exc",     0, 1, 4'd0, 32'h0000_3100, 32'h0,       32'h0, 26'h0,       1, 0, 32'h0,       32'h0000_3104, 0, 0);
        cyc("exc_free",   0, 0, 4'd0, 32'h0000_3100, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_4180, 0, 0);
        cyc("st_eret",    0, 1, 4'd0, 32'h0000_4180, 32'h0,       32'h0, 26'h0,       0, 1, 32'h3020,    32'h0000_4184, 0, 0);
        cyc("exc_eret",   0, 0, 4'd0, 32'h0000_3020, 32'h0,       32'h0, 26'h0,       1, 1, 32'h5000,    32'h0000_3020, 0, 0);
        cyc("blez0",      0, 0, 4'd3, 32'h0000_4180, 32'h0,       32'h0, 26'h2,       0, 0, 32'h0,       32'h0000_4180, 1, 0);
        cyc("bltz_m1",    0, 0, 4'd5, 32'h0000_4188, 32'hFFFF_FFFF, 32'h0, 26'hFFFE,  0, 0, 32'h0,       32'h0000_418C, 1, 0);
        cyc("bgez_neg",   0, 0, 4'd6, 32'h0000_4184, 32'h8000_0000, 32'h0, 26'h10,    0, 0, 32'h0,       32'h0000_4184, 0, 0);
        cyc("op12_seq",   0, 0, 4'd12, 32'h0000_4188, 32'h7,      32'h7, 26'h10,      0, 0, 32'h0,       32'h0000_4188, 0, 0);
        cyc("rst_exc",    1, 0, 4'd0, 32'h0000_4188, 32'h0,       32'h0, 26'h0,       1, 0, 32'h0,       32'h0000_418C, 0, 0);
        cyc("jr_top",     0, 0, 4'd8, 32'h0000_3000, 32'hFFFF_FFFC, 32'h0, 26'h0,     0, 0, 32'h0,       32'h0000_3000, 1, 0);
        cyc("wrap",       0, 0, 4'd0, 32'hFFFF_FFFC, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'hFFFF_FFFC, 0, 0);
`ifdef PC_ALIGN_CHK_EN
        cyc("jr_mis",     0, 0, 4'd8, 32'h0000_0000, 32'h3102,    32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_0000, 1, 0);
        cyc("adel_hi",    0, 0, 4'd0, 32'h0000_0000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_4180, 0, 1);
        cyc("adel_lo",    0, 0, 4'd0, 32'h0000_0000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_4184, 0, 0);
`else
        cyc("after_wrap", 0, 0, 4'd0, 32'h0000_0000, 32'h0,       32'h0, 26'h0,       0, 0, 32'h0,       32'h0000_0000, 0, 0);
`endif
        @(negedge clk);
        #1;
        chk("drain", "queue", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
